// File: rtl/calc_disp_pkg.sv
// Shared constants for the calculator display path: digit codes, BCD width, FSM encoding.
package calc_disp_pkg;

   localparam int BCD_W = 20;

   localparam logic [3:0] DIG_MINUS = 4'd10;
   localparam logic [3:0] DIG_E     = 4'd11;
   localparam logic [3:0] DIG_BLANK = 4'd12;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_FORMAT = 2'd2
   } state_t;

endpackage

// File: rtl/dabble_cell.sv
// One BCD nibble of the double-dabble correction: add 3 when the nibble is 5 or more.
module dabble_cell (
   input  logic [3:0] nib_i,
   output logic [3:0] nib_o
);

   assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/bin_to_digits.sv
// Signed binary to four display digit codes via iterative double dabble.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros and float the minus sign.
module bin_to_digits
   import calc_disp_pkg::*;
#(
   parameter int IN_W = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [IN_W-1:0] value,
   output logic            busy,
   output logic            done,
   output logic [3:0]      d3,
   output logic [3:0]      d2,
   output logic [3:0]      d1,
   output logic [3:0]      d0,
   output logic [1:0]      state_dbg
);

   localparam int MAG_W = IN_W - 1;
   localparam int CNT_W = 5;
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(IN_W - 2);

   state_t            state_q, state_d;
   logic              sign_q, mneg_q, done_q;
   logic [MAG_W-1:0]  mag_q;
   logic [BCD_W-1:0]  acc_q, acc_adj;
   logic [CNT_W-1:0]  cnt_q;
   logic [3:0]        d3_q, d2_q, d1_q, d0_q;
   logic [3:0]        f3, f2, f1, f0;
   logic [IN_W-1:0]   neg_val;
   logic [MAG_W-1:0]  mag_in;
   logic              accept;

   // The done cycle still belongs to the conversion, so a start there is dropped.
   assign accept  = start && (state_q == ST_IDLE) && !done_q;
   assign neg_val = -value;
   assign mag_in  = value[IN_W-1] ? neg_val[MAG_W-1:0] : value[MAG_W-1:0];

   for (genvar g = 0; g < BCD_W / 4; g++) begin : g_cell
      dabble_cell u_cell (
         .nib_i (acc_q[4*g +: 4]),
         .nib_o (acc_adj[4*g +: 4])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (accept) state_d = ST_SHIFT;
         ST_SHIFT:  if (cnt_q == LAST_SHIFT) state_d = ST_FORMAT;
         ST_FORMAT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != ST_IDLE);
      done      = done_q;
      state_dbg = state_q;
      d3 = d3_q;
      d2 = d2_q;
      d1 = d1_q;
      d0 = d0_q;
   end

   always_comb begin
      logic [3:0] b4, b3, b2, b1, b0;
      logic       ovf, show3, show2, show1;
      b4 = acc_q[19:16];
      b3 = acc_q[15:12];
      b2 = acc_q[11:8];
      b1 = acc_q[7:4];
      b0 = acc_q[3:0];
      ovf = mneg_q || (b4 != 4'd0) || (sign_q && (b3 != 4'd0));
`ifdef LEADING_ZERO_BLANK_EN
      show3 = (b3 != 4'd0);
      show2 = show3 || (b2 != 4'd0);
      show1 = show2 || (b1 != 4'd0);
      f3 = show3 ? b3 : DIG_BLANK;
      f2 = show2 ? b2 : DIG_BLANK;
      f1 = show1 ? b1 : DIG_BLANK;
      f0 = b0;
      // In-range negatives never use d3 for a numeral, so the minus always fits.
      if (sign_q) begin
         if (show2)      f3 = DIG_MINUS;
         else if (show1) f2 = DIG_MINUS;
         else            f1 = DIG_MINUS;
      end
`else
      show3 = 1'b0;
      show2 = 1'b0;
      show1 = 1'b0;
      f3 = sign_q ? DIG_MINUS : b3;
      f2 = b2;
      f1 = b1;
      f0 = b0;
`endif
      if (ovf) begin
         f3 = DIG_E;
         f2 = DIG_BLANK;
         f1 = DIG_BLANK;
         f0 = DIG_BLANK;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sign_q <= 1'b0;
         mneg_q <= 1'b0;
         mag_q  <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
         d3_q   <= DIG_BLANK;
         d2_q   <= DIG_BLANK;
         d1_q   <= DIG_BLANK;
         d0_q   <= DIG_BLANK;
      end else begin
         done_q <= (state_q == ST_FORMAT);
         if (accept) begin
            sign_q <= value[IN_W-1];
            mneg_q <= (value == {1'b1, {MAG_W{1'b0}}});
            mag_q  <= mag_in;
            acc_q  <= '0;
            cnt_q  <= '0;
         end else if (state_q == ST_SHIFT) begin
            acc_q <= {acc_adj[BCD_W-2:0], mag_q[MAG_W-1]};
            mag_q <= mag_q << 1;
            cnt_q <= cnt_q + 1'b1;
         end
         if (state_q == ST_FORMAT) begin
            d3_q <= f3;
            d2_q <= f2;
            d1_q <= f1;
            d0_q <= f0;
         end
      end
   end

endmodule
